// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: single-outstanding req/ack port, pipeline stall,
// watchdog abort, and aligned sign/zero-extended load return.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] EX_MEM_mem,
  input  logic [31:0] EX_MEM_addr,
  input  logic [31:0] EX_MEM_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic [31:0] MEM_rdata,
  output logic        mem_done,
  output logic        misalign_err,
  output logic        bus_err
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;

  logic          mem_rd, mem_wr, ld_uns, access, misaligned, accept, wd_expire;
  logic [1:0]    size;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [1:0]    size_r, lane_r;
  logic          uns_r, timed_out;
  logic [CW-1:0] cnt;
  logic          unused_bits;

  assign mem_rd      = EX_MEM_mem[12];
  assign mem_wr      = EX_MEM_mem[11];
  assign size        = EX_MEM_mem[10:9];
  assign ld_uns      = EX_MEM_mem[8];
  assign unused_bits = ^EX_MEM_mem[7:0];
  assign access      = mem_rd | mem_wr;

  always_comb begin
    misaligned = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = EX_MEM_wdata;
    if (size[1]) begin
      misaligned = (EX_MEM_addr[1:0] != 2'b00);
    end else if (size[0]) begin
      misaligned = EX_MEM_addr[0];
      be_c       = EX_MEM_addr[1] ? 4'b1100 : 4'b0011;
      wdata_c    = {2{EX_MEM_wdata[15:0]}};
    end else begin
      be_c       = 4'b0001 << EX_MEM_addr[1:0];
      wdata_c    = {4{EX_MEM_wdata[7:0]}};
    end
  end

  assign misalign_err = access & misaligned;
  assign accept       = (state == IDLE) & access & ~misaligned;
  assign wd_expire    = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Lane is picked from the address captured at accept, not the live bundle.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                         input logic uns, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    if (sz[1])      return w;
    else if (sz[0]) return {{16{h[15] & ~uns}}, h};
    else            return {{24{b[7] & ~uns}}, b};
  endfunction

  always_comb begin
    state_nx  = state;
    mem_stall = 1'b0;
    mem_done  = 1'b0;
    bus_err   = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = accept;
        if (accept) state_nx = WAIT;
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (dmem_ack || wd_expire) state_nx = RESP;
      end
      RESP: begin
        mem_done = 1'b1;
        bus_err  = timed_out;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      MEM_rdata  <= '0;
      size_r     <= '0;
      lane_r     <= '0;
      uns_r      <= 1'b0;
      timed_out  <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          dmem_req   <= 1'b1;
          dmem_we    <= mem_wr;
          dmem_addr  <= {EX_MEM_addr[31:2], 2'b00};
          dmem_be    <= be_c;
          dmem_wdata <= wdata_c;
          size_r     <= size;
          uns_r      <= ld_uns;
          lane_r     <= EX_MEM_addr[1:0];
          timed_out  <= 1'b0;
          cnt        <= '0;
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          // Ack has priority over a watchdog expiring in the same cycle.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) MEM_rdata <= extend(dmem_rdata, size_r, uns_r, lane_r);
          end else if (wd_expire) begin
            dmem_req  <= 1'b0;
            timed_out <= 1'b1;
            if (!dmem_we) MEM_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] EX_MEM_mem;
  logic [31:0] EX_MEM_addr, EX_MEM_wdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack, mem_stall, mem_done, misalign_err, bus_err;
  logic [31:0] MEM_rdata;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .EX_MEM_mem(EX_MEM_mem), .EX_MEM_addr(EX_MEM_addr),
    .EX_MEM_wdata(EX_MEM_wdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .MEM_rdata(MEM_rdata), .mem_done(mem_done), .misalign_err(misalign_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  int n_stall, n_req, done_cyc, done_a;
  logic got_done, got_bus, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] mk(input logic rd, input logic wr, input logic [1:0] sz,
                                     input logic uns);
    return {rd, wr, sz, uns, 8'hA5};
  endfunction

  // Called just after a negedge; returns in the RESP cycle (or after the bound expires).
  task automatic run(input logic [12:0] m, input logic [31:0] a, input logic [31:0] w,
                     input int k, input logic [31:0] rd);
    EX_MEM_mem = m; EX_MEM_addr = a; EX_MEM_wdata = w; dmem_rdata = rd; dmem_ack = 1'b0;
    n_stall = 0; n_req = 0; got_done = 1'b0; got_bus = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      #1;
      if (mem_stall) n_stall++;
      if (mem_done) begin
        got_done = 1'b1; got_bus = bus_err; done_cyc = cyc;
      end
      if (dmem_req) begin
        n_req++;
        if (n_req == 1) begin
          cap_addr = dmem_addr; cap_be = dmem_be; cap_we = dmem_we; cap_wdata = dmem_wdata;
        end
      end
      dmem_ack = dmem_req && (n_req == k);
      if (!got_done) @(negedge clk);
    end
    dmem_ack = 1'b0;
    chk("completion_seen", {31'd0, got_done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; EX_MEM_mem = '0; EX_MEM_addr = '0; EX_MEM_wdata = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_rdata", MEM_rdata, 32'd0);
    chk("rst_done", {31'd0, mem_done}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word load, ack three cycles after req rises.
    run(mk(1, 0, 2'b10, 0), 32'h100, 32'h0, 3, 32'hDEADBEEF);
    chk("wl_addr", cap_addr, 32'h100);
    chk("wl_be", {28'd0, cap_be}, 32'hF);
    chk("wl_we", {31'd0, cap_we}, 32'd0);
    chk("wl_stalls", n_stall, 4);
    chk("wl_req_cycles", n_req, 3);
    chk("wl_rdata", MEM_rdata, 32'hDEADBEEF);
    chk("wl_bus_err", {31'd0, got_bus}, 32'd0);
    EX_MEM_mem = '0;
    @(negedge clk); #1;
    chk("wl_done_one_cycle", {31'd0, mem_done}, 32'd0);

    // Signed then unsigned byte load from lane 3.
    run(mk(1, 0, 2'b00, 0), 32'h103, 32'h0, 1, 32'h80FF0000);
    chk("sb_be", {28'd0, cap_be}, 32'h8);
    chk("sb_addr", cap_addr, 32'h100);
    chk("sb_rdata", MEM_rdata, 32'hFFFFFF80);
    chk("sb_stalls", n_stall, 2);
    @(negedge clk);
    run(mk(1, 0, 2'b00, 1), 32'h103, 32'h0, 1, 32'h80FF0000);
    chk("ub_rdata", MEM_rdata, 32'h00000080);
    @(negedge clk);

    // Half store to upper half: MEM_rdata must hold the previous load value.
    run(mk(0, 1, 2'b01, 0), 32'h202, 32'h1234ABCD, 2, 32'h55555555);
    chk("hs_addr", cap_addr, 32'h200);
    chk("hs_be", {28'd0, cap_be}, 32'hC);
    chk("hs_we", {31'd0, cap_we}, 32'd1);
    chk("hs_wdata", cap_wdata, 32'hABCDABCD);
    chk("hs_rdata_held", MEM_rdata, 32'h00000080);
    @(negedge clk);

    // Read+write both set is treated as a byte write replicated across lanes.
    run(mk(1, 1, 2'b00, 0), 32'h301, 32'h000000E7, 1, 32'h0);
    chk("rw_we", {31'd0, cap_we}, 32'd1);
    chk("rw_be", {28'd0, cap_be}, 32'h2);
    chk("rw_wdata", cap_wdata, 32'hE7E7E7E7);
    chk("rw_rdata_held", MEM_rdata, 32'h00000080);
    EX_MEM_mem = '0;
    @(negedge clk);

    // Misaligned word load: flagged, never requested, never stalls.
    EX_MEM_mem = mk(1, 0, 2'b10, 0); EX_MEM_addr = 32'h101;
    #1;
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_stall", {31'd0, mem_stall}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_done", {31'd0, mem_done}, 32'd0);
    EX_MEM_mem = mk(1, 0, 2'b01, 0); EX_MEM_addr = 32'h103;
    #1;
    chk("mis_half_err", {31'd0, misalign_err}, 32'd1);
    EX_MEM_mem = '0;
    @(negedge clk);

    // Ack outside WAIT is ignored.
    dmem_rdata = 32'h12345678; dmem_ack = 1'b1;
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("stray_ack_rdata", MEM_rdata, 32'h00000080);
    chk("stray_ack_done", {31'd0, mem_done}, 32'd0);

    // Watchdog: no ack, req for exactly 16 cycles, bus_err with mem_done, rdata cleared.
    run(mk(1, 0, 2'b10, 0), 32'h300, 32'h0, 0, 32'hFFFFFFFF);
    chk("to_req_cycles", n_req, 16);
    chk("to_stalls", n_stall, 17);
    chk("to_bus_err", {31'd0, got_bus}, 32'd1);
    chk("to_rdata", MEM_rdata, 32'd0);
    EX_MEM_mem = '0;
    @(negedge clk); #1;
    chk("to_bus_err_pulse", {31'd0, bus_err}, 32'd0);

    // Ack on the final watchdog cycle wins.
    run(mk(1, 0, 2'b10, 0), 32'h304, 32'h0, 16, 32'hCAFEF00D);
    chk("race_bus_err", {31'd0, got_bus}, 32'd0);
    chk("race_rdata", MEM_rdata, 32'hCAFEF00D);
    @(negedge clk);

    // Back-to-back loads, one-cycle ack each.
    run(mk(1, 0, 2'b01, 0), 32'h102, 32'h0, 1, 32'h8001_7FFF);
    done_a = done_cyc;
    chk("b2b_half_rdata", MEM_rdata, 32'hFFFF8001);
    @(negedge clk);
    run(mk(1, 0, 2'b00, 1), 32'h101, 32'h0, 1, 32'h0000C300);
    chk("b2b_byte_rdata", MEM_rdata, 32'h000000C3);
    chk("b2b_spacing", done_cyc - done_a, 3);
    @(negedge clk);

    // Reset in the middle of an access.
    EX_MEM_mem = mk(1, 0, 2'b10, 0); EX_MEM_addr = 32'h400;
    for (int c = 0; c < 5 && !dmem_req; c++) @(negedge clk);
    #1;
    chk("mid_req_high", {31'd0, dmem_req}, 32'd1);
    #1;
    rst_n = 1'b0; EX_MEM_mem = '0;
    #1;
    chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("mid_rst_addr", dmem_addr, 32'd0);
    chk("mid_rst_be", {28'd0, dmem_be}, 32'd0);
    chk("mid_rst_rdata", MEM_rdata, 32'd0);
    chk("mid_rst_stall", {31'd0, mem_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0; #1;
    chk("mid_rst_no_done", {31'd0, mem_done}, 32'd0);
    chk("mid_rst_no_rdata", MEM_rdata, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access controller for the 5-stage MIPS pipeline. Consumes the memory control bundle, address and store data held in the EX/MEM register and drives a single-outstanding req/ack data-memory port. While an access is in flight it stalls the pipeline, which freezes EX/MEM. It returns aligned, sign- or zero-extended load data to the MEM/WB path.

## Interface
- TIMEOUT, default 16: cycles to wait for `dmem_ack` before aborting with a bus error; 0 disables the watchdog.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- EX_MEM_mem  in  13  control bundle:
  - [12] mem_rd, [11] mem_wr, [10:9] size (00 byte, 01 half, 10/11 word), [8] ld_unsigned.
  - [7:0] reserved and ignored.
- EX_MEM_addr  in  32  byte address from ALU
- EX_MEM_wdata  in  32  store data (right-justified)
- dmem_req  out  1  request, high for the whole access
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_be  out  4  byte enables, little-endian
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read word, valid with ack
- dmem_ack  in  1  one-cycle completion strobe
- mem_stall  out  1  hold IF/ID/EX and EX/MEM
- MEM_rdata  out  32  aligned and extended load result
- mem_done  out  1  one-cycle pulse: access completed
- misalign_err  out  1  combinational: current bundle is misaligned
- bus_err  out  1  one-cycle pulse: watchdog expired

## Operation
- FSM states IDLE, WAIT, RESP.
- Access present: mem_rd | mem_wr. If both are set, the access is a write.
- Misalignment:
  - half with addr[0]=1; word with addr[1:0]≠0.
  - In IDLE, a misaligned access raises `misalign_err`, issues no request and raises no stall; the state stays IDLE.
- IDLE → WAIT on an aligned access. On that edge the unit registers:
  - `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`;
  - size, ld_unsigned and addr[1:0] for load extension.
- Byte enables:
  - byte: 4'b0001 << addr[1:0];
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1;
  - word: 1111.
- Store data:
  - byte: {4{wdata[7:0]}};
  - half: {2{wdata[15:0]}};
  - word: wdata.
- WAIT:
  - `dmem_req`=1; request outputs stay stable.
  - The watchdog counter increments each cycle, starting at 0 on entry.
  - On `dmem_ack`: for a read, capture the extended data into MEM_rdata; go to RESP.
  - If TIMEOUT≠0 and the count reaches TIMEOUT-1 with no ack: drop the request, go to RESP, pulse `bus_err` in RESP, and set MEM_rdata=0 for a read.
- Load extension: select the lane by the registered addr[1:0].
  - byte: sign- or zero-extend from bit 7;
  - half: sign- or zero-extend from bit 15.
- RESP:
  - `mem_done`=1 and `mem_stall`=0.
  - EX/MEM advances at the end of RESP; the still-present bundle must not retrigger an access.
  - RESP → IDLE unconditionally.
- MEM_rdata changes only on a read completion or timeout. It holds its value otherwise, including across writes.
- `dmem_ack` outside WAIT is ignored.

## Timing
- mem_stall = (IDLE & aligned access) | WAIT. It is combinational, so the stall is seen in the same cycle the access appears.
- With ack sampled k cycles after the WAIT entry edge (k≥1), the access stalls for k+1 cycles. The minimum is 2 stall cycles plus 1 RESP cycle.
- `dmem_req` is registered: it rises the cycle after the access is accepted and falls on the edge that samples ack or timeout.
- Back-to-back accesses: a new access can be accepted in the IDLE cycle directly after RESP.
- Reset values: state IDLE, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_be 0, dmem_wdata 0, MEM_rdata 0, mem_done 0, bus_err 0, counter 0.
- Reset asserted mid-access forces `dmem_req` low immediately (asynchronous). No completion is reported.
- Ack and timeout in the same cycle: ack wins, with no `bus_err`.

## Test plan
- Word load, addr 0x100, ack 3 cycles after req rises, rdata 0xDEADBEEF:
  - dmem_addr=0x100, be=1111;
  - stall for 4 cycles, then MEM_rdata=0xDEADBEEF with mem_done for 1 cycle.
- Signed byte load, addr 0x103, rdata 0x80FF0000 → be=1000, MEM_rdata=0xFFFFFF80. Same access with ld_unsigned=1 → 0x00000080.
- Half store, addr 0x202, wdata 0x1234ABCD:
  - dmem_addr=0x200, be=1100, we=1, dmem_wdata=0xABCDABCD;
  - MEM_rdata is unchanged.
- Misaligned word load, addr 0x101 → misalign_err=1, dmem_req stays 0, mem_stall=0.
- TIMEOUT=16 with no ack:
  - req is high for exactly 16 cycles;
  - bus_err and mem_done pulse together; MEM_rdata=0.
- Two back-to-back loads, ack after 1 cycle each → two mem_done pulses 3 cycles apart. Then assert rst_n=0 during WAIT → dmem_req falls asynchronously and all outputs return to their reset values.
